arm_multicycle_core: RTL and testbench
======================================

// Module: arm_multicycle_core
// PURPOSE
//  Multicycle ARM-subset core: one FSM sequences fetch, decode, execute, memory and writeback.
//  Fetch and load/store use request/acknowledge handshakes, so instruction and data memories may stall.
//  Adds conditional execution, B, rotated immediates, an optional register shifter and R15-as-PC.
//  Internal 16x32 register file and NZCV flags.
// PARAMETERS
//  ADDR_W    32  width of pc/instr_addr/mem_addr (<=32); addresses are the low ADDR_W bits of the 32-bit value
//  RESET_PC  0   pc value loaded on reset
//  SHIFT_EN  1   1: register operand Rm passes through LSL/LSR/ASR/ROR #imm5; 0: shift field ignored
//  UNDEF_NOP 0   1: undefined encodings retire as NOP; 0: they enter HALT
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous reset, active-low
//  instr_req    out  1       fetch request, held until instr_valid
//  instr_addr   out  ADDR_W  fetch address (= pc)
//  instr_valid  in   1       instr is valid this cycle
//  instr        in   32      fetched instruction
//  mem_req      out  1       data request, held until mem_ack
//  mem_we       out  1       1 = store
//  mem_addr     out  ADDR_W  word address (bits[1:0] forced 0)
//  mem_wdata    out  32      store data (Rd)
//  mem_ack      in   1       access complete; mem_rdata valid if load
//  mem_rdata    in   32      load data
//  pc           out  ADDR_W  address of the instruction in flight
//  flags        out  4       {N,Z,C,V}
//  halted       out  1       core in HALT
// BEHAVIOUR
//  Reset (rst=0, async): state=FETCH, pc=RESET_PC, R0-R14=0, flags=0, all req/we/halted=0.
//   Any in-flight handshake is abandoned; no register or flag write completes.
//  States: FETCH, DECODE, EXEC, MEM, WB, HALT.
//  FETCH: instr_req=1. On instr_valid: latch IR -> DECODE. Otherwise stay in FETCH.
//  DECODE: read Rn, Rd, Rm; evaluate cond[31:28] against flags (EQ..LE, AL=1110).
//   Cond fails (or cond=1111): pc+=4 -> FETCH. Undefined: HALT, or NOP if UNDEF_NOP. Else -> EXEC.
//  Encoding op[27:26]:
//   00 DP: cmd[24:21] AND0000 EOR0001 SUB0010 RSB0011 ADD0100 ORR1100 MOV1101 CMP1010; other cmd undefined.
//      I[25]=1: imm8 rotated right by 2*rot[11:8]. I=0: Rm, shifted by sh[6:5]/imm5[11:7] (SHIFT_EN).
//      Bit4=1 (register-specified shift) is undefined. Shift amount 0 = unshifted operand.
//   01 LDR/STR: imm12 offset, U[23]=1 add / 0 subtract, L[20]=1 load.
//      I[25]=1, B[22]=1, P[24]=0 or W[21]=1 are undefined.
//   10 B (bit25=1, bit24=0): target = pc+8+(sext(imm24)<<2). BL (bit24=1) is undefined.
//   11 undefined.
//  Reads of R15 return pc+8.
//  EXEC:
//   DP non-CMP -> WB. CMP: write flags -> FETCH, pc+=4.
//   LDR/STR: form address -> MEM. B: pc=target -> FETCH.
//  MEM: mem_req=1, mem_we=~L, addr/wdata held stable until mem_ack.
//   On ack: store -> FETCH, pc+=4; load -> WB with rdata latched.
//  WB: write Rd.
//   Rd=R15: pc=result & ~3. Otherwise pc+=4. -> FETCH.
//  Flags: written only when S[20]=1 (DP) or on CMP.
//   N=res[31], Z=(res==0). Add: C=carry-out; sub/RSB/CMP: C=NOT borrow, V=signed overflow.
//   Logical ops and MOV: C=shifter carry-out (unchanged if unshifted); V unchanged.
//  Cycle counts with zero-wait memories: DP 4, CMP 3, B 3, STR 4, LDR 5, cond-fail 2.
//   Each wait cycle adds one cycle.
//  HALT: halted=1, all req=0, no state change until reset.
//  pc and address arithmetic wrap modulo 2^ADDR_W. instr_valid/mem_ack outside FETCH/MEM are ignored.
// TESTING
//  1. MOV R1,#5; ADD R2,R1,#3 (S=1), zero-wait -> R2=8, NZCV=0000, 8 cycles total, pc=8.
//  2. R1=0x80000000; SUBS R0,R1,#1 -> R0=0x7FFFFFFF, N=0 Z=0 C=1 V=1.
//  3. STR R2,[R0,#4] then LDR R3,[R0,#4] with 3-cycle mem_ack delay:
//     req/addr held stable; R3=R2; the store takes 7 cycles, the load 8.
//  4. CMP R1,R1; BNE +8; BEQ -2 words:
//     BNE falls through in 2 cycles; BEQ sets pc = its address+8-8 = its own address (loops).
//  5. Assert rst=0 mid-MEM with mem_req=1 -> mem_req drops the same cycle.
//     After release: pc=RESET_PC, regs=0.
//  6. Fetch 0xEC000000 (op=11), UNDEF_NOP=0 -> halted=1, instr_req stays 0; UNDEF_NOP=1 -> pc+=4.

Source files
------------

// File: rtl/arm_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module   : arm_multicycle_core
// Purpose  : Multicycle ARM-subset core. One FSM steps through the
//            FETCH/DECODE/EXEC/MEM/WB states. Instruction and data memories
//            use req/ack handshakes, so either memory may stall the core.
//            Supports conditional execution, B, rotated immediates, an
//            optional Rm shifter, and R15 as the PC. Holds a 16x32 register
//            file and NZCV flags.
// Ports    : clk, rst_n                  clock (rising), async active-low reset
//            o_instr_req/addr            fetch request / address (= pc)
//            i_instr_valid, i_instr      fetch response
//            o_mem_req/we/addr/wdata     data request (addr word-aligned)
//            i_mem_ack, i_mem_rdata      data response
//            o_pc, o_flags, o_halted     pc in flight, {N,Z,C,V}, HALT state
// Revision : 1.0 - initial release
// ============================================================================
module arm_multicycle_core #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          SHIFT_EN  = 1,
  parameter int          UNDEF_NOP = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              o_instr_req,
  output logic [ADDR_W-1:0] o_instr_addr,
  input  logic              i_instr_valid,
  input  logic [31:0]       i_instr,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata,
  output logic [ADDR_W-1:0] o_pc,
  output logic [3:0]        o_flags,
  output logic              o_halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] c_AND = 4'b0000;
  localparam logic [3:0] c_EOR = 4'b0001;
  localparam logic [3:0] c_SUB = 4'b0010;
  localparam logic [3:0] c_RSB = 4'b0011;
  localparam logic [3:0] c_ADD = 4'b0100;
  localparam logic [3:0] c_CMP = 4'b1010;
  localparam logic [3:0] c_ORR = 4'b1100;
  localparam logic [3:0] c_MOV = 4'b1101;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ir;
  logic [31:0]       r_regs [0:15];   // entry 15 is never written; R15 reads come from pc
  logic [3:0]        r_flags;
  logic [31:0]       r_opa, r_opb, r_rdv, r_result;
  logic              r_shc;
  logic [ADDR_W-1:0] r_maddr;

  // Instruction fields
  logic [3:0] w_cond, w_cmd, w_rn, w_rd, w_rm, w_rot;
  logic [1:0] w_op, w_sh;
  logic [4:0] w_imm5;
  logic       w_i, w_s;
  assign w_cond = r_ir[31:28];
  assign w_op   = r_ir[27:26];
  assign w_i    = r_ir[25];
  assign w_cmd  = r_ir[24:21];
  assign w_s    = r_ir[20];        // S for DP, L for load/store
  assign w_rn   = r_ir[19:16];
  assign w_rd   = r_ir[15:12];
  assign w_rot  = r_ir[11:8];
  assign w_imm5 = r_ir[11:7];
  assign w_sh   = r_ir[6:5];
  assign w_rm   = r_ir[3:0];

  logic [31:0]       w_pc32, w_pc8, w_rn_val, w_rd_val, w_rm_val;
  logic [ADDR_W-1:0] w_pc_inc;
  always_comb begin
    w_pc32             = '0;
    w_pc32[ADDR_W-1:0] = r_pc;
  end
  assign w_pc8    = w_pc32 + 32'd8;
  assign w_pc_inc = r_pc + ADDR_W'(4);
  assign w_rn_val = (w_rn == 4'd15) ? w_pc8 : r_regs[w_rn];
  assign w_rd_val = (w_rd == 4'd15) ? w_pc8 : r_regs[w_rd];
  assign w_rm_val = (w_rm == 4'd15) ? w_pc8 : r_regs[w_rm];

  // Condition evaluation against current flags
  logic w_n, w_z, w_c, w_v, w_cond_pass;
  assign {w_n, w_z, w_c, w_v} = r_flags;
  always_comb begin
    w_cond_pass = 1'b0;
    case (w_cond)
      4'b0000: w_cond_pass = w_z;
      4'b0001: w_cond_pass = ~w_z;
      4'b0010: w_cond_pass = w_c;
      4'b0011: w_cond_pass = ~w_c;
      4'b0100: w_cond_pass = w_n;
      4'b0101: w_cond_pass = ~w_n;
      4'b0110: w_cond_pass = w_v;
      4'b0111: w_cond_pass = ~w_v;
      4'b1000: w_cond_pass = w_c & ~w_z;
      4'b1001: w_cond_pass = ~w_c | w_z;
      4'b1010: w_cond_pass = (w_n == w_v);
      4'b1011: w_cond_pass = (w_n != w_v);
      4'b1100: w_cond_pass = ~w_z & (w_n == w_v);
      4'b1101: w_cond_pass = w_z | (w_n != w_v);
      4'b1110: w_cond_pass = 1'b1;
      default: w_cond_pass = 1'b0;
    endcase
  end

  // Instruction class decode
  logic w_cmd_ok, w_is_dp, w_is_ls, w_is_b, w_undef, w_is_cmp;
  always_comb begin
    case (w_cmd)
      c_AND, c_EOR, c_SUB, c_RSB, c_ADD, c_ORR, c_MOV, c_CMP: w_cmd_ok = 1'b1;
      default:                                                w_cmd_ok = 1'b0;
    endcase
  end
  assign w_is_dp  = (w_op == 2'b00) & w_cmd_ok & ~(~w_i & r_ir[4]);
  assign w_is_ls  = (w_op == 2'b01) & ~w_i & ~r_ir[22] & r_ir[24] & ~r_ir[21];
  assign w_is_b   = (w_op == 2'b10) & r_ir[25] & ~r_ir[24];
  assign w_undef  = ~(w_is_dp | w_is_ls | w_is_b);
  assign w_is_cmp = (w_cmd == c_CMP);

  // Operand-2 shifter; the extra bit in the 33-bit forms captures carry-out
  logic [31:0] w_op2;
  logic        w_shc;
  logic [32:0] w_t33;
  logic [63:0] w_t64;
  always_comb begin
    w_op2 = w_rm_val;
    w_shc = w_c;
    w_t33 = '0;
    w_t64 = '0;
    if (w_i) begin
      w_t64 = {24'd0, r_ir[7:0], 24'd0, r_ir[7:0]} >> {w_rot, 1'b0};
      w_op2 = w_t64[31:0];
      w_shc = (w_rot == 4'd0) ? w_c : w_op2[31];
    end else if ((SHIFT_EN != 0) && (w_imm5 != 5'd0)) begin
      case (w_sh)
        2'b00: begin
          w_t33 = {1'b0, w_rm_val} << w_imm5;
          w_op2 = w_t33[31:0];
          w_shc = w_t33[32];
        end
        2'b01: begin
          w_t33 = {w_rm_val, 1'b0} >> w_imm5;
          w_op2 = w_t33[32:1];
          w_shc = w_t33[0];
        end
        2'b10: begin
          w_t33 = 33'($signed({w_rm_val, 1'b0}) >>> w_imm5);
          w_op2 = w_t33[32:1];
          w_shc = w_t33[0];
        end
        default: begin
          w_t64 = {w_rm_val, w_rm_val} >> w_imm5;
          w_op2 = w_t64[31:0];
          w_shc = w_op2[31];
        end
      endcase
    end
  end

  // ALU on latched operands
  logic [31:0] w_alu_res;
  logic [3:0]  w_alu_flags;
  logic [32:0] w_sum;
  always_comb begin
    w_alu_res   = '0;
    w_sum       = '0;
    w_alu_flags = r_flags;
    case (w_cmd)
      c_AND: w_alu_res = r_opa & r_opb;
      c_EOR: w_alu_res = r_opa ^ r_opb;
      c_ORR: w_alu_res = r_opa | r_opb;
      c_MOV: w_alu_res = r_opb;
      c_SUB, c_CMP: begin
        w_sum          = {1'b0, r_opa} + {1'b0, ~r_opb} + 33'd1;
        w_alu_res      = w_sum[31:0];
        w_alu_flags[1] = w_sum[32];
        w_alu_flags[0] = (r_opa[31] ^ r_opb[31]) & (w_alu_res[31] ^ r_opa[31]);
      end
      c_RSB: begin
        w_sum          = {1'b0, r_opb} + {1'b0, ~r_opa} + 33'd1;
        w_alu_res      = w_sum[31:0];
        w_alu_flags[1] = w_sum[32];
        w_alu_flags[0] = (r_opb[31] ^ r_opa[31]) & (w_alu_res[31] ^ r_opb[31]);
      end
      c_ADD: begin
        w_sum          = {1'b0, r_opa} + {1'b0, r_opb};
        w_alu_res      = w_sum[31:0];
        w_alu_flags[1] = w_sum[32];
        w_alu_flags[0] = ~(r_opa[31] ^ r_opb[31]) & (w_alu_res[31] ^ r_opa[31]);
      end
      default: w_alu_res = '0;
    endcase
    // Logical ops take C from the shifter (already equals C when unshifted)
    if ((w_cmd == c_AND) || (w_cmd == c_EOR) || (w_cmd == c_ORR) || (w_cmd == c_MOV))
      w_alu_flags[1] = r_shc;
    w_alu_flags[3] = w_alu_res[31];
    w_alu_flags[2] = (w_alu_res == 32'd0);
  end

  logic [31:0] w_ea, w_btgt, w_res_al;
  assign w_ea     = r_ir[23] ? (r_opa + {20'd0, r_ir[11:0]}) : (r_opa - {20'd0, r_ir[11:0]});
  assign w_btgt   = w_pc8 + {{6{r_ir[23]}}, r_ir[23:0], 2'b00};
  assign w_res_al = {r_result[31:2], 2'b00};

  // Next-state and outputs
  always_comb begin
    w_next      = r_state;
    o_instr_req = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_halted    = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_instr_req = rst_n;     // held low while reset is asserted
        if (i_instr_valid) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (!w_cond_pass)  w_next = S_FETCH;
        else if (w_undef)  w_next = (UNDEF_NOP != 0) ? S_FETCH : S_HALT;
        else               w_next = S_EXEC;
      end
      S_EXEC: begin
        if (w_is_dp)      w_next = w_is_cmp ? S_FETCH : S_WB;
        else if (w_is_ls) w_next = S_MEM;
        else              w_next = S_FETCH;
      end
      S_MEM: begin
        o_mem_req = 1'b1;
        o_mem_we  = ~w_s;
        if (i_mem_ack) w_next = w_s ? S_WB : S_FETCH;
      end
      S_WB:    w_next = S_FETCH;
      S_HALT: begin
        o_halted = 1'b1;
        w_next   = S_HALT;
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC[ADDR_W-1:0];
      r_ir     <= '0;
      r_flags  <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_rdv    <= '0;
      r_result <= '0;
      r_shc    <= 1'b0;
      r_maddr  <= '0;
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (i_instr_valid) r_ir <= i_instr;
        S_DECODE: begin
          r_opa <= w_rn_val;
          r_opb <= w_op2;
          r_shc <= w_shc;
          r_rdv <= w_rd_val;
          if (!w_cond_pass || (w_undef && (UNDEF_NOP != 0))) r_pc <= w_pc_inc;
        end
        S_EXEC: begin
          if (w_is_dp) begin
            r_result <= w_alu_res;
            if (w_s || w_is_cmp) r_flags <= w_alu_flags;
            if (w_is_cmp)        r_pc    <= w_pc_inc;
          end else if (w_is_ls) begin
            r_maddr <= {w_ea[ADDR_W-1:2], 2'b00};
          end else if (w_is_b) begin
            r_pc <= w_btgt[ADDR_W-1:0];
          end
        end
        S_MEM: begin
          if (i_mem_ack) begin
            if (w_s) r_result <= i_mem_rdata;
            else     r_pc     <= w_pc_inc;
          end
        end
        S_WB: begin
          if (w_rd == 4'd15) begin
            r_pc <= w_res_al[ADDR_W-1:0];
          end else begin
            r_regs[w_rd] <= r_result;
            r_pc         <= w_pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_instr_addr = r_pc;
  assign o_pc         = r_pc;
  assign o_flags      = r_flags;
  assign o_mem_addr   = r_maddr;
  assign o_mem_wdata  = r_rdv;

endmodule
`default_nettype wire

// File: tb/tb_arm_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_arm_multicycle_core
// Purpose  : Directed bench for arm_multicycle_core with behavioural
//            instruction/data memories and a store scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arm_multicycle_core;

  localparam logic [31:0] c_BSELF = 32'hEAFFFFFE;   // B . (branch to itself)

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        o_instr_req, i_instr_valid, o_mem_req, o_mem_we, i_mem_ack, o_halted;
  logic [31:0] o_instr_addr, i_instr, o_mem_addr, o_mem_wdata, i_mem_rdata, o_pc;
  logic [3:0]  o_flags;

  logic        n_instr_req, n_instr_valid, n_mem_req, n_mem_we, n_halted;
  logic [31:0] n_instr_addr, n_instr, n_mem_addr, n_mem_wdata, n_pc;
  logic [3:0]  n_flags;

  arm_multicycle_core #(.ADDR_W(32), .RESET_PC(32'h0), .SHIFT_EN(1), .UNDEF_NOP(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .o_instr_req(o_instr_req), .o_instr_addr(o_instr_addr),
    .i_instr_valid(i_instr_valid), .i_instr(i_instr),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_pc(o_pc), .o_flags(o_flags), .o_halted(o_halted)
  );

  arm_multicycle_core #(.ADDR_W(32), .RESET_PC(32'h0), .SHIFT_EN(1), .UNDEF_NOP(1)) u_nop (
    .clk(clk), .rst_n(rst_n),
    .o_instr_req(n_instr_req), .o_instr_addr(n_instr_addr),
    .i_instr_valid(n_instr_valid), .i_instr(n_instr),
    .o_mem_req(n_mem_req), .o_mem_we(n_mem_we), .o_mem_addr(n_mem_addr),
    .o_mem_wdata(n_mem_wdata), .i_mem_ack(1'b0), .i_mem_rdata(32'd0),
    .o_pc(n_pc), .o_flags(n_flags), .o_halted(n_halted)
  );

  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:63];
  int iwait = 0, dwait = 0, icnt = 0, dcnt = 0, fetch_cnt = 0;
  logic        stable_err = 1'b0;
  logic [31:0] st_addr, st_wdata;
  logic        st_we;

  typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;
  st_t exp_q[$];
  st_t obs_q[$];

  int n_cmp = 0, n_fail = 0;

  // Instruction memory, responds iwait cycles after the request appears
  always @(negedge clk) begin
    if (o_instr_req) begin
      if (icnt >= iwait) begin
        i_instr_valid = 1'b1;
        i_instr       = imem[o_instr_addr[7:2]];
        icnt          = 0;
        fetch_cnt     = fetch_cnt + 1;
      end else begin
        i_instr_valid = 1'b0;
        icnt          = icnt + 1;
      end
    end else begin
      i_instr_valid = 1'b0;
      icnt          = 0;
    end
  end

  // Zero-wait fetch for the UNDEF_NOP instance
  always @(negedge clk) begin
    n_instr_valid = n_instr_req;
    n_instr       = imem[n_instr_addr[7:2]];
  end

  // Data memory with dwait wait cycles; records stores and request stability
  always @(negedge clk) begin
    if (o_mem_req) begin
      if (dcnt == 0) begin
        st_addr = o_mem_addr; st_wdata = o_mem_wdata; st_we = o_mem_we;
      end else if (o_mem_addr !== st_addr || o_mem_wdata !== st_wdata || o_mem_we !== st_we) begin
        stable_err = 1'b1;
      end
      if (dcnt >= dwait) begin
        i_mem_ack = 1'b1;
        if (o_mem_we) begin
          dmem[o_mem_addr[7:2]] = o_mem_wdata;
          obs_q.push_back('{o_mem_addr, o_mem_wdata});
        end else begin
          i_mem_rdata = dmem[o_mem_addr[7:2]];
        end
        dcnt = 0;
      end else begin
        i_mem_ack = 1'b0;
        dcnt      = dcnt + 1;
      end
    end else begin
      i_mem_ack = 1'b0;
      dcnt      = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < 64; i++) begin
      imem[i] = c_BSELF;
      dmem[i] = 32'd0;
    end
  endtask

  // Assert reset mid-cycle, clear scoreboard, release mid-cycle
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    exp_q.delete();
    obs_q.delete();
    stable_err = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic wait_pc(input string tag, input logic [31:0] target, output int cyc);
    cyc = 0;
    while (o_pc !== target && cyc < 200) begin
      tick();
      cyc++;
    end
    chk({tag, "_reach"}, o_pc, target);
  endtask

  task automatic check_stores(input string tag);
    st_t e, o;
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_addr"}, o.addr, e.addr);
      chk({tag, "_data"}, o.data, e.data);
    end
  endtask

  initial begin
    int cyc;
    int f0;
    i_instr_valid = 1'b0; i_instr = '0; i_mem_ack = 1'b0; i_mem_rdata = '0;
    n_instr_valid = 1'b0; n_instr = '0;

    // ---- 1: MOV R1,#5 ; ADDS R2,R1,#3 ; STR R2,[R0,#0x10]
    load_prog();
    imem[0] = 32'hE3A01005;
    imem[1] = 32'hE2912003;
    imem[2] = 32'hE5802010;
    iwait = 0; dwait = 0;
    rst_n = 1'b0;
    tick();
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_flags", {28'd0, o_flags}, 32'h0);
    chk("rst_halted", {31'd0, o_halted}, 32'h0);
    chk("rst_instr_req", {31'd0, o_instr_req}, 32'h0);
    chk("rst_mem_req", {31'd0, o_mem_req}, 32'h0);
    do_reset();
    exp_q.push_back('{32'h10, 32'd8});
    wait_pc("t1_pc8", 32'd8, cyc);
    chk("t1_cycles", cyc, 8);
    chk("t1_flags", {28'd0, o_flags}, 32'h0);
    wait_pc("t1_pc12", 32'd12, cyc);
    check_stores("t1_store");

    // ---- 2: SUBS overflow, ASR/LSL shifter flags, R15 read
    load_prog();
    imem[0] = 32'hE3A01102;   // MOV  R1,#0x80000000
    imem[1] = 32'hE2510001;   // SUBS R0,R1,#1
    imem[2] = 32'hE5820020;   // STR  R0,[R2,#0x20]
    imem[3] = 32'hE1B04241;   // MOVS R4,R1,ASR #4
    imem[4] = 32'hE5824024;   // STR  R4,[R2,#0x24]
    imem[5] = 32'hE0345081;   // EORS R5,R4,R1,LSL #1
    imem[6] = 32'hE28F6000;   // ADD  R6,R15,#0
    imem[7] = 32'hE5826028;   // STR  R6,[R2,#0x28]
    do_reset();
    exp_q.push_back('{32'h20, 32'h7FFFFFFF});
    exp_q.push_back('{32'h24, 32'hF8000000});
    exp_q.push_back('{32'h28, 32'd32});
    wait_pc("t2_subs", 32'd8, cyc);
    chk("t2_subs_flags", {28'd0, o_flags}, 32'h3);
    wait_pc("t2_asr", 32'd16, cyc);
    chk("t2_asr_flags", {28'd0, o_flags}, 32'h9);
    wait_pc("t2_lsl", 32'd24, cyc);
    chk("t2_lsl_flags", {28'd0, o_flags}, 32'hB);
    wait_pc("t2_end", 32'd32, cyc);
    check_stores("t2_store");

    // ---- 3: STR / LDR with 3 data wait cycles
    load_prog();
    imem[0] = 32'hE3A02055;   // MOV R2,#0x55
    imem[1] = 32'hE5802004;   // STR R2,[R0,#4]
    imem[2] = 32'hE5903004;   // LDR R3,[R0,#4]
    imem[3] = 32'hE5803008;   // STR R3,[R0,#8]
    dwait = 3;
    do_reset();
    exp_q.push_back('{32'h4, 32'h55});
    exp_q.push_back('{32'h8, 32'h55});
    wait_pc("t3_mov", 32'd4, cyc);
    chk("t3_mov_cycles", cyc, 4);
    wait_pc("t3_str", 32'd8, cyc);
    chk("t3_str_cycles", cyc, 7);
    wait_pc("t3_ldr", 32'd12, cyc);
    chk("t3_ldr_cycles", cyc, 8);
    wait_pc("t3_end", 32'd16, cyc);
    chk("t3_stable", {31'd0, stable_err}, 32'h0);
    check_stores("t3_store");

    // ---- 4: CMP R1,R1 ; BNE (not taken) ; BEQ to itself
    load_prog();
    imem[0] = 32'hE1510001;
    imem[1] = 32'h1A000000;
    imem[2] = 32'h0AFFFFFE;
    dwait = 0;
    do_reset();
    wait_pc("t4_cmp", 32'd4, cyc);
    chk("t4_cmp_cycles", cyc, 3);
    chk("t4_cmp_flags", {28'd0, o_flags}, 32'h6);
    wait_pc("t4_bne", 32'd8, cyc);
    chk("t4_bne_cycles", cyc, 2);
    f0 = fetch_cnt;
    for (int i = 0; i < 9; i++) tick();
    chk("t4_beq_fetches", fetch_cnt - f0, 3);
    chk("t4_beq_pc", o_pc, 32'd8);

    // ---- 5: reset while a store is stalled in MEM
    load_prog();
    imem[0] = 32'hE3A01007;   // MOV R1,#7
    imem[1] = 32'hE5801040;   // STR R1,[R0,#0x40]
    dwait = 20;
    do_reset();
    cyc = 0;
    while (!o_mem_req && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("t5_mem_req_up", {31'd0, o_mem_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t5_mem_req_drop", {31'd0, o_mem_req}, 32'h0);
    chk("t5_rst_pc", o_pc, 32'h0);
    imem[0] = 32'hE5801044;   // STR R1,[R0,#0x44]
    imem[1] = c_BSELF;
    dwait = 0;
    do_reset();
    exp_q.push_back('{32'h44, 32'h0});
    wait_pc("t5_after", 32'd4, cyc);
    check_stores("t5_store");

    // ---- 6: undefined op=11 halts (UNDEF_NOP=0) or retires as NOP (UNDEF_NOP=1)
    load_prog();
    imem[0] = 32'hEC000000;
    do_reset();
    tick();
    tick();
    chk("t6_nop_pc", n_pc, 32'd4);
    chk("t6_nop_halted", {31'd0, n_halted}, 32'h0);
    chk("t6_halted", {31'd0, o_halted}, 32'h1);
    for (int i = 0; i < 5; i++) tick();
    chk("t6_halt_stays", {31'd0, o_halted}, 32'h1);
    chk("t6_halt_instr_req", {31'd0, o_instr_req}, 32'h0);
    chk("t6_halt_pc", o_pc, 32'h0);

    // ---- 7: fetch wait states stretch FETCH
    load_prog();
    imem[0] = 32'hE3A01005;
    iwait = 2;
    do_reset();
    wait_pc("t7_mov", 32'd4, cyc);
    chk("t7_cycles", cyc, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
